// File: rtl/slice_serial_adder_pkg.sv
// Shared constants for the slice-serial adder.
// Optional build macro: SLICE_SERIAL_ADDER_OVF_EN adds the signed overflow flag.
`ifndef SLICE_SERIAL_ADDER_PKG_SV
`define SLICE_SERIAL_ADDER_PKG_SV

`define SLICE_SERIAL_ADDER_CHECK(W, S) \
  if (((W) % (S)) != 0) begin : g_width_check \
    $error("WIDTH must be a multiple of SLICE"); \
  end

package slice_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`endif

// File: rtl/slice_serial_adder_add_slice.sv
// Combinational SLICE-bit ripple-carry adder.
// Built as a chain of 1-bit full adders.
module add_slice
  import slice_serial_adder_pkg::*;
#(
  parameter int SLICE = 4
) (
  output logic [SLICE-1:0] sum,
  output logic             cout,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/slice_serial_adder.sv
// Wide adder that processes SLICE bits per clock through one adder slice.
// Optional build macro: SLICE_SERIAL_ADDER_OVF_EN adds output ovf.
module slice_serial_adder
  import slice_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SLICE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  `SLICE_SERIAL_ADDER_CHECK(WIDTH, SLICE)

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [SLICE-1:0] s_a;
  logic [SLICE-1:0] s_b;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic [WIDTH-1:0] sum_nxt;

  assign s_a = a_q[SLICE-1:0];
  assign s_b = b_q[SLICE-1:0];

  add_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .sum (s_sum),
    .cout(s_cout),
    .a   (s_a),
    .b   (s_b),
    .cin (carry)
  );

  // New slice result enters at the top; earlier slices move down.
  assign sum_nxt = (sum >> SLICE)
                 | (WIDTH'(s_sum) << (WIDTH - SLICE));

`ifdef SLICE_SERIAL_ADDER_OVF_EN
  logic msb_cin;

  // Carry into the operand MSB recovered from the final slice's top bit.
  assign msb_cin = s_a[SLICE-1] ^ s_b[SLICE-1] ^ s_sum[SLICE-1];
`endif

  // Sequencer: capture, shift through the slice, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef SLICE_SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> SLICE;
          b_q   <= b_q >> SLICE;
          sum   <= sum_nxt;
          carry <= s_cout;
          if (cnt == LAST) begin
            cout      <= s_cout;
`ifdef SLICE_SERIAL_ADDER_OVF_EN
            ovf       <= s_cout ^ msb_cin;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
